// File: rtl/proto_sort_pkg.sv
// Shared constants and types for the proto_sort loader and read-side mux.
// Both ends take their select width from SEL_W so they always agree.
package proto_sort_pkg;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = SEL_W + 1;

  typedef logic [WIDTH-1:0] nibble_t;
  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } loader_state_t;

endpackage

// File: rtl/datamux.sv
// 8:1 nibble select mux used downstream to read the loader's slot bank.
module datamux
  import proto_sort_pkg::*;
(
  input  sel_t    sel_i,
  input  nibble_t zero_i,
  input  nibble_t one_i,
  input  nibble_t two_i,
  input  nibble_t three_i,
  input  nibble_t four_i,
  input  nibble_t five_i,
  input  nibble_t six_i,
  input  nibble_t seven_i,
  output nibble_t data_o
);

  always_comb begin
    data_o = zero_i;
    case (sel_i)
      3'd1:    data_o = one_i;
      3'd2:    data_o = two_i;
      3'd3:    data_o = three_i;
      3'd4:    data_o = four_i;
      3'd5:    data_o = five_i;
      3'd6:    data_o = six_i;
      3'd7:    data_o = seven_i;
      default: data_o = zero_i;
    endcase
  end

endmodule

// File: rtl/data_loader.sv
// Scatters a valid/ready stream of nibbles into an eight-slot register bank,
// holds the bank while full until released, and flushes on a synchronous clear.
module data_loader
  import proto_sort_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  nibble_t in_data_i,
  input  logic    in_valid_i,
  output logic    in_ready_o,
  input  logic    clear_i,
  input  logic    release_i,
  output nibble_t zero_o,
  output nibble_t one_o,
  output nibble_t two_o,
  output nibble_t three_o,
  output nibble_t four_o,
  output nibble_t five_o,
  output nibble_t six_o,
  output nibble_t seven_o,
  output sel_t    wr_ptr_o,
  output cnt_t    count_o,
  output logic    full_o,
  output logic    done_o
);

  loader_state_t state_q;
  nibble_t       bank_q [DEPTH];
  sel_t          wr_ptr_q;
  cnt_t          count_q;
  logic          done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FILL;
      wr_ptr_q <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      // NOTE: the bank is eight discrete registers whose reset value is visible
      // on the outputs, so it is reset like any other state (not a RAM).
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      if (clear_i) begin
        state_q  <= FILL;
        wr_ptr_q <= '0;
        count_q  <= '0;
        for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
      end else begin
        case (state_q)
          FILL: begin
            if (in_valid_i) begin
              bank_q[wr_ptr_q] <= in_data_i;
              wr_ptr_q         <= wr_ptr_q + 3'd1;  // 7 wraps to 0 on the last write
              count_q          <= count_q + 4'd1;
              if (count_q == CNT_W'(DEPTH - 1)) begin
                state_q <= FULL;
                done_q  <= 1'b1;
              end
            end
          end
          FULL: begin
            if (release_i) begin
              state_q  <= FILL;
              wr_ptr_q <= '0;
              count_q  <= '0;
            end
          end
          default: state_q <= FILL;
        endcase
      end
    end
  end

  // Ready and full are decoded from the state register alone, never from in_valid.
  assign in_ready_o = (state_q == FILL);
  assign full_o     = (state_q == FULL);
  assign done_o     = done_q;
  assign wr_ptr_o   = wr_ptr_q;
  assign count_o    = count_q;

  assign zero_o  = bank_q[0];
  assign one_o   = bank_q[1];
  assign two_o   = bank_q[2];
  assign three_o = bank_q[3];
  assign four_o  = bank_q[4];
  assign five_o  = bank_q[5];
  assign six_o   = bank_q[6];
  assign seven_o = bank_q[7];

endmodule

// File: tb/tb_data_loader.sv
// Directed and randomized bench for data_loader against a slot-array model,
// reading the bank back both directly and through datamux.
module tb_data_loader;
  import proto_sort_pkg::*;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  nibble_t in_data = '0;
  logic    in_valid = 1'b0;
  logic    in_ready;
  logic    clear = 1'b0;
  logic    rel = 1'b0;
  nibble_t zero, one, two, three, four, five, six, seven;
  sel_t    wr_ptr;
  cnt_t    count;
  logic    full, done;
  sel_t    sel = '0;
  nibble_t mux_data;

  int errors = 0;
  int checks = 0;

  // Model: slot contents, number written this batch, full flag, done pulse.
  logic [3:0] m_bank [8];
  int         m_cnt;
  bit         m_full;
  bit         m_done;

  data_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data_i  (in_data),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .clear_i    (clear),
    .release_i  (rel),
    .zero_o     (zero),
    .one_o      (one),
    .two_o      (two),
    .three_o    (three),
    .four_o     (four),
    .five_o     (five),
    .six_o      (six),
    .seven_o    (seven),
    .wr_ptr_o   (wr_ptr),
    .count_o    (count),
    .full_o     (full),
    .done_o     (done)
  );

  datamux u_mux (
    .sel_i   (sel),
    .zero_i  (zero),
    .one_i   (one),
    .two_i   (two),
    .three_i (three),
    .four_i  (four),
    .five_i  (five),
    .six_i   (six),
    .seven_i (seven),
    .data_o  (mux_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_bank[i] = 4'h0;
    m_cnt  = 0;
    m_full = 1'b0;
    m_done = 1'b0;
  endtask

  // One clock edge of the loader's rules, applied to the inputs present at the edge.
  task automatic model_step();
    m_done = 1'b0;
    if (clear) begin
      model_reset();
    end else if (!m_full) begin
      if (in_valid) begin
        m_bank[m_cnt] = in_data;
        m_cnt++;
        if (m_cnt == 8) begin
          m_full = 1'b1;
          m_done = 1'b1;
        end
      end
    end else if (rel) begin
      m_full = 1'b0;
      m_cnt  = 0;
    end
  endtask

  task automatic check_all(input string ph);
    logic [3:0] slots [8];
    slots = '{zero, one, two, three, four, five, six, seven};
    for (int i = 0; i < 8; i++)
      check($sformatf("%s.slot%0d", ph, i), 32'(slots[i]), 32'(m_bank[i]));
    check({ph, ".count"},    32'(count),    32'(m_cnt));
    check({ph, ".wr_ptr"},   32'(wr_ptr),   32'(m_cnt % 8));
    check({ph, ".full"},     32'(full),     32'(m_full));
    check({ph, ".done"},     32'(done),     32'(m_done));
    check({ph, ".in_ready"}, 32'(in_ready), 32'(!m_full));
    check({ph, ".mux"},      32'(mux_data), 32'(m_bank[sel]));
  endtask

  task automatic cycle(input string ph);
    @(posedge clk);
    model_step();
    #1;
    check_all(ph);
  endtask

  task automatic drive(input string ph, input logic v, input logic [3:0] d,
                       input logic r, input logic c);
    in_valid = v;
    in_data  = d;
    rel      = r;
    clear    = c;
    sel      = sel_t'($urandom_range(0, 7));
    cycle(ph);
  endtask

  task automatic idle(input string ph);
    drive(ph, 1'b0, 4'(($urandom)), 1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] batch [8];
    batch = '{4'h7, 4'h3, 4'hF, 4'h0, 4'h9, 4'h1, 4'hC, 4'h5};

    // Reset state
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle("post_reset");

    // Eight back-to-back writes, then full/done timing
    for (int i = 0; i < 8; i++) drive("batch", 1'b1, batch[i], 1'b0, 1'b0);
    check("batch.done_pulse", 32'(done), 32'd1);
    idle("after_done");
    check("after_done.done_low", 32'(done), 32'd0);

    // Writes offered while full are ignored
    for (int i = 0; i < 5; i++) drive("full_hold", 1'b1, 4'hA, 1'b0, 1'b0);
    check("full_hold.count8", 32'(count), 32'd8);

    // Release then a new first write
    drive("release", 1'b0, 4'h0, 1'b1, 1'b0);
    drive("rewrite", 1'b1, 4'h2, 1'b0, 1'b0);
    check("rewrite.zero", 32'(zero), 32'h2);
    check("rewrite.seven_kept", 32'(seven), 32'h5);

    // Gapped writes, then clear colliding with a handshake
    drive("gaps", 1'b1, 4'h4, 1'b0, 1'b0);
    idle("gaps");
    drive("gaps", 1'b1, 4'h8, 1'b0, 1'b0);
    idle("gaps");
    idle("gaps");
    drive("gaps", 1'b1, 4'hB, 1'b0, 1'b0);
    drive("clear_hs", 1'b1, 4'hE, 1'b0, 1'b1);
    check("clear_hs.count0", 32'(count), 32'd0);

    // Asynchronous reset with count = 5
    for (int i = 0; i < 5; i++) drive("pre_rst", 1'b1, 4'(($urandom)), 1'b0, 1'b0);
    in_valid = 1'b0;
    clear    = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    idle("after_rst");
    check("after_rst.in_ready", 32'(in_ready), 32'd1);

    // Eighth write collides with clear: no full, no done
    for (int i = 0; i < 7; i++) drive("pre_clr8", 1'b1, 4'(($urandom)), 1'b0, 1'b0);
    drive("clear8", 1'b1, 4'h6, 1'b0, 1'b1);
    check("clear8.full", 32'(full), 32'd0);
    idle("clear8_next");
    check("clear8_next.done", 32'(done), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 300; n++)
      drive("rand", 1'($urandom_range(0, 1)), 4'(($urandom)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 24) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
